// File: rtl/keypad_encoder.sv
// Keypad front-end: synchronizes, debounces and binary-encodes eight push-buttons
// into an ITEM_CODE / single-cycle KEY_PRESS pair for the vending FSM.
module keypad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] KEY_RAW,
  output logic [2:0] ITEM_CODE,
  output logic       KEY_PRESS,
  output logic       MULTI_KEY
);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  state_t     state, state_nx;
  logic [7:0] s1, key_s;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] cand, cand_nx;
  logic [2:0] item_nx;
  logic       press_nx;

  logic       key_zero, key_onehot, key_multi;
  logic [2:0] key_enc;
  logic [7:0] cand_onehot;
  logic [8:0] cnt_inc;
  logic       cnt_done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1    <= '0;
      key_s <= '0;
    end else begin
      s1    <= KEY_RAW;
      key_s <= s1;
    end
  end

  // x & (x-1) clears the lowest set bit: zero result on a nonzero x means one-hot
  always_comb begin
    key_zero   = (key_s == '0);
    key_onehot = !key_zero && ((key_s & (key_s - 8'd1)) == '0);
    key_multi  = !key_zero && !key_onehot;
  end

  always_comb begin
    key_enc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (key_s[i]) key_enc = 3'(i);
    end
  end

  always_comb begin
    cand_onehot = 8'd1 << cand;
    cnt_inc     = {1'b0, cnt} + 9'd1;
    cnt_done    = (cnt_inc == 9'(DEBOUNCE_CYCLES));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    item_nx  = ITEM_CODE;
    press_nx = 1'b0;
    case (state)
      IDLE: begin
        if (key_onehot) begin
          cand_nx  = key_enc;
          cnt_nx   = 8'd1;
          state_nx = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (key_s == cand_onehot) begin
          if (cnt_done) begin
            press_nx = 1'b1;
            item_nx  = cand;
            cnt_nx   = '0;
            state_nx = HELD;
          end else begin
            cnt_nx = cnt_inc[7:0];
          end
        end else begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      HELD: begin
        if (key_zero) begin
          cnt_nx   = 8'd1;
          state_nx = DEB_REL;
        end
      end
      DEB_REL: begin
        if (key_zero) begin
          if (cnt_done) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt_inc[7:0];
          end
        end else begin
          cnt_nx   = '0;
          state_nx = HELD;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      ITEM_CODE <= '0;
      KEY_PRESS <= 1'b0;
      MULTI_KEY <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      ITEM_CODE <= item_nx;
      KEY_PRESS <= press_nx;
      MULTI_KEY <= key_multi;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed vector table, hand-written bounce/reset
// sequences and randomized key activity checked against a run-length model.
module tb_keypad_encoder;

  localparam int DC = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] KEY_RAW = '0;
  logic [2:0] ITEM_CODE;
  logic       KEY_PRESS;
  logic       MULTI_KEY;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .KEY_RAW   (KEY_RAW),
    .ITEM_CODE (ITEM_CODE),
    .KEY_PRESS (KEY_PRESS),
    .MULTI_KEY (MULTI_KEY)
  );

  always #5 CLK = ~CLK;

  // Reference: a two-sample delay line feeding press/release run-length counting.
  logic [7:0] m_s1 = '0, m_ks = '0, want = '0;
  int         streak = 0, zrun = 0;
  bit         armed = 1'b1;
  logic [2:0] e_code = '0;
  logic       e_press = 1'b0, e_multi = 1'b0;

  always @(posedge CLK) begin
    logic [7:0] s;
    if (RESET) begin
      m_s1 = '0; m_ks = '0; want = '0;
      armed = 1'b1; streak = 0; zrun = 0;
      e_press = 1'b0; e_code = '0; e_multi = 1'b0;
    end else begin
      s = m_ks;
      e_press = 1'b0;
      e_multi = ($countones(s) > 1);
      if (armed) begin
        if (streak > 0 && s == want) streak++;
        else if (streak > 0) streak = 0;
        else if ($countones(s) == 1) begin
          want = s;
          streak = 1;
        end
        if (streak == DC) begin
          e_press = 1'b1;
          for (int i = 0; i < 8; i++) if (want[i]) e_code = 3'(i);
          armed = 1'b0;
          streak = 0;
          zrun = 0;
        end
      end else begin
        if (s == 8'h00) zrun++;
        else zrun = 0;
        if (zrun == DC) begin
          armed = 1'b1;
          zrun = 0;
        end
      end
      m_ks = m_s1;
      m_s1 = KEY_RAW;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [7:0] raw);
    KEY_RAW = raw;
    @(posedge CLK);
    #1;
    chk("model_press", 32'(KEY_PRESS), 32'(e_press));
    chk("model_code",  32'(ITEM_CODE), 32'(e_code));
    chk("model_multi", 32'(MULTI_KEY), 32'(e_multi));
  endtask

  typedef struct {
    logic [7:0] raw;
    int         hold;
    int         presses;
    logic [2:0] code;
    logic       multi;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int presses, first;
    logic [7:0] raw;

    vecs[0]  = '{8'h04, 10, 1, 3'd2, 1'b0};
    vecs[1]  = '{8'h00,  6, 0, 3'd2, 1'b0};
    vecs[2]  = '{8'h04,  8, 1, 3'd2, 1'b0};
    vecs[3]  = '{8'h00,  6, 0, 3'd2, 1'b0};
    vecs[4]  = '{8'h80,  8, 1, 3'd7, 1'b0};
    vecs[5]  = '{8'h00,  6, 0, 3'd7, 1'b0};
    vecs[6]  = '{8'h06,  8, 0, 3'd7, 1'b1};
    vecs[7]  = '{8'h04,  8, 1, 3'd2, 1'b0};
    vecs[8]  = '{8'h00,  6, 0, 3'd2, 1'b0};
    vecs[9]  = '{8'h20, 40, 1, 3'd5, 1'b0};
    vecs[10] = '{8'h22,  8, 0, 3'd5, 1'b1};
    vecs[11] = '{8'h00,  6, 0, 3'd5, 1'b0};

    RESET = 1'b1;
    cycle(8'h00);
    cycle(8'h00);
    chk("reset_code",  32'(ITEM_CODE), 32'd0);
    chk("reset_press", 32'(KEY_PRESS), 32'd0);
    chk("reset_multi", 32'(MULTI_KEY), 32'd0);
    RESET = 1'b0;
    cycle(8'h00);

    foreach (vecs[v]) begin
      presses = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        cycle(vecs[v].raw);
        if (KEY_PRESS) presses++;
      end
      chk($sformatf("vec%0d_presses", v), 32'(presses), 32'(vecs[v].presses));
      chk($sformatf("vec%0d_code", v),    32'(ITEM_CODE), 32'(vecs[v].code));
      chk($sformatf("vec%0d_multi", v),   32'(MULTI_KEY), 32'(vecs[v].multi));
    end

    // Press bounce, then stable digit 3; acceptance counted from the stable level
    for (int c = 0; c < 8; c++) cycle(8'h00);
    cycle(8'h08); cycle(8'h00); cycle(8'h08); cycle(8'h00);
    presses = 0;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      cycle(8'h08);
      if (KEY_PRESS) begin
        presses++;
        if (first < 0) first = c;
      end
    end
    chk("bounce_presses", 32'(presses), 32'd1);
    chk("bounce_latency", 32'(first), 32'(DC + 1));
    chk("bounce_code",    32'(ITEM_CODE), 32'd3);
    presses = 0;
    cycle(8'h00); cycle(8'h08); cycle(8'h00);
    for (int c = 0; c < 8; c++) begin
      cycle(8'h00);
      if (KEY_PRESS) presses++;
    end
    chk("release_bounce_presses", 32'(presses), 32'd0);

    // Reset while digit 6 is mid-debounce, then re-acceptance after release of reset
    presses = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(8'h40);
      if (KEY_PRESS) presses++;
    end
    RESET = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle(8'h40);
      if (KEY_PRESS) presses++;
      chk("rst_mid_code",  32'(ITEM_CODE), 32'd0);
      chk("rst_mid_press", 32'(KEY_PRESS), 32'd0);
      chk("rst_mid_multi", 32'(MULTI_KEY), 32'd0);
    end
    chk("rst_pre_presses", 32'(presses), 32'd0);
    RESET = 1'b0;
    presses = 0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cycle(8'h40);
      if (KEY_PRESS) begin
        presses++;
        if (first < 0) first = k;
      end
    end
    chk("rst_post_latency", 32'(first), 32'(DC + 2));
    chk("rst_post_presses", 32'(presses), 32'd1);
    chk("rst_post_code",    32'(ITEM_CODE), 32'd6);

    for (int seg = 0; seg < 250; seg++) begin
      int sel, hold;
      sel = $urandom_range(0, 9);
      if (sel < 4) raw = 8'h00;
      else if (sel < 8) raw = 8'h01 << $urandom_range(0, 7);
      else if (sel == 8) raw = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
      else raw = 8'($urandom);
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) begin
        RESET = 1'b1;
        cycle(raw);
        RESET = 1'b0;
      end
      for (int c = 0; c < hold; c++) cycle(raw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
